// File: rtl/led_sched_pkg.sv
// Shared types and defaults for the LED status scheduler.
//   state_e       : scheduler FSM state encoding (ST_IDLE, ST_SHOW)
//   *_DEF         : default pattern width and requester count
package led_sched_pkg;

    localparam int unsigned LED_WIDTH_DEF = 4;
    localparam int unsigned NUM_REQ_DEF   = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_e;

endpackage

// File: rtl/led_sched_if.sv
// Requester/LED-register bundle for led_sched.
//   req, req_value, req_blink : per-source request, pattern, blink enable
//   grant, busy               : current owner (one-hot) and display-active flag
//   led_en, led_value         : load strobe and pattern for the LED register
// master = requester/register side, slave = scheduler side.
interface led_sched_if
    import led_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
    parameter int unsigned LED_WIDTH = LED_WIDTH_DEF
);

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*LED_WIDTH-1:0] req_value;
    logic [NUM_REQ-1:0]           req_blink;
    logic [NUM_REQ-1:0]           grant;
    logic                         busy;
    logic                         led_en;
    logic [LED_WIDTH-1:0]         led_value;

    modport master (
        output req, req_value, req_blink,
        input  grant, busy, led_en, led_value
    );

    modport slave (
        input  req, req_value, req_blink,
        output grant, busy, led_en, led_value
    );

endinterface

// File: rtl/led_prio_enc.sv
// Combinational fixed-priority encoder; bit 0 wins.
//   req      : request vector
//   onehot_c : one-hot of the lowest set bit (zero when none)
//   idx_c    : index of the lowest set bit (zero when none)
//   any_c    : at least one bit set
module led_prio_enc #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [N-1:0]  onehot_c,
    output logic [IW-1:0] idx_c,
    output logic          any_c
);

    // Scan high to low so the lowest set index is written last.
    always_comb begin
        onehot_c = '0;
        idx_c    = '0;
        any_c    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot_c    = '0;
                onehot_c[i] = 1'b1;
                idx_c       = IW'(i);
                any_c       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_sched.sv
// LED status scheduler: picks one status source, shows its pattern (optionally
// blinking) for at least HOLD_MIN cycles, and drives the LED register load port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : led_sched_if.slave (requests in; grant/busy/led_en/led_value out)
module led_sched
    import led_sched_pkg::*;
#(
    parameter int unsigned LED_WIDTH  = LED_WIDTH_DEF,
    parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
    parameter int unsigned HOLD_MIN   = 50_000_000,
    parameter int unsigned BLINK_HALF = 25_000_000
) (
    input logic        clk,
    input logic        rst_n,
    led_sched_if.slave bus
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned HW = (HOLD_MIN > 1) ? $clog2(HOLD_MIN) : 1;
    localparam int unsigned BW = $clog2(BLINK_HALF);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_MIN - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic                 busy_q, busy_d;
    logic                 led_en_q, led_en_d;
    logic [LED_WIDTH-1:0] led_value_q, led_value_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [BW-1:0]        blink_q, blink_d;
    logic                 phase_q, phase_d;

    logic [NUM_REQ-1:0]   enc_onehot_c;
    logic [IW-1:0]        enc_idx_c;
    logic                 enc_any_c;
    logic [LED_WIDTH-1:0] enc_val_c;
    logic [LED_WIDTH-1:0] owner_val_c;
    logic                 owner_blink_c;
    logic                 hold_done_c;
    logic                 take_c;

    // One encoder over the raw request vector serves both the idle grant and
    // re-arbitration: if it still points at the owner, nothing better is waiting.
    led_prio_enc #(.N(NUM_REQ)) u_enc (
        .req      (bus.req),
        .onehot_c (enc_onehot_c),
        .idx_c    (enc_idx_c),
        .any_c    (enc_any_c)
    );

    assign enc_val_c     = bus.req_value[int'(enc_idx_c) * LED_WIDTH +: LED_WIDTH];
    assign owner_val_c   = bus.req_value[int'(owner_q) * LED_WIDTH +: LED_WIDTH];
    assign owner_blink_c = bus.req_blink[owner_q];
    assign hold_done_c   = (hold_q == HOLD_LAST);

    // Next-state and next-output logic; at most one led_en per cycle, with a
    // switch/idle transition taking precedence over blink or live updates.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        busy_d      = busy_q;
        led_en_d    = 1'b0;
        led_value_d = led_value_q;
        hold_d      = hold_q;
        blink_d     = blink_q;
        phase_d     = phase_q;
        take_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                take_c = enc_any_c;
            end
            ST_SHOW: begin
                if (hold_done_c && (!enc_any_c || (enc_idx_c != owner_q))) begin
                    if (enc_any_c) begin
                        take_c = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        grant_d     = '0;
                        busy_d      = 1'b0;
                        led_en_d    = 1'b1;
                        led_value_d = '0;
                        hold_d      = '0;
                        blink_d     = '0;
                        phase_d     = 1'b1;
                    end
                end else begin
                    if (!hold_done_c) begin
                        hold_d = hold_q + 1'b1;
                    end
                    if (owner_blink_c) begin
                        if (blink_q == BLINK_LAST) begin
                            blink_d     = '0;
                            phase_d     = !phase_q;
                            led_en_d    = 1'b1;
                            led_value_d = phase_q ? '0 : owner_val_c;
                        end else begin
                            blink_d = blink_q + 1'b1;
                            if (phase_q && (owner_val_c != led_value_q)) begin
                                led_en_d    = 1'b1;
                                led_value_d = owner_val_c;
                            end
                        end
                    end else begin
                        // Steady display: restore the pattern if caught in the off phase.
                        blink_d = '0;
                        phase_d = 1'b1;
                        if (!phase_q || (owner_val_c != led_value_q)) begin
                            led_en_d    = 1'b1;
                            led_value_d = owner_val_c;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_c) begin
            state_d     = ST_SHOW;
            grant_d     = enc_onehot_c;
            owner_d     = enc_idx_c;
            busy_d      = 1'b1;
            led_en_d    = 1'b1;
            led_value_d = enc_val_c;
            hold_d      = '0;
            blink_d     = '0;
            phase_d     = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            busy_q      <= 1'b0;
            led_en_q    <= 1'b0;
            led_value_q <= '0;
            hold_q      <= '0;
            blink_q     <= '0;
            phase_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            led_en_q    <= led_en_d;
            led_value_q <= led_value_d;
            hold_q      <= hold_d;
            blink_q     <= blink_d;
            phase_q     <= phase_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.led_en    = led_en_q;
    assign bus.led_value = led_value_q;

endmodule
